famipad_serializer: RTL
=======================

Name: famipad_serializer

Overview:
- Parametrised successor to the single-pad Famicom controller emulation in the sim top; drives the Gigatron famicom_latch/famicom_pulse/famicom_data serial protocol.
- Supports NUM_PADS pads of PAD_BITS bits each (8 = NES, 16 = SNES-style).
- Runtime-selectable parallel mode (one data line per pad) or daisy-chain mode (all pads on data[0]).
- Merges the active-low keyboard bitmap into pad 0; reports shift count and over-read.

Parameters:
NUM_PADS, 2, number of pads (1..4)
PAD_BITS, 8, bits per pad (8 or 16)
FILL_BIT, 1'b1, value shifted in behind the last real bit (1 = released)

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-high
chain_en  in  1  1 = daisy-chain mode, 0 = parallel; sampled only at latch load
pad_buttons  in  NUM_PADS*PAD_BITS  active-high buttons; pad p occupies [p*PAD_BITS +: PAD_BITS]; bit 0 is shifted out first (caller does button reordering)
kbd_n  in  PAD_BITS  active-low keyboard bitmap, merged into pad 0 only
famicom_latch  in  1  latch from core, active-high
famicom_pulse  in  1  shift clock from core
famicom_data  out  NUM_PADS  serial data, active-low (0 = pressed)
bit_count  out  CNT_W  saturating count of shifts since last latch; CNT_W = $clog2(NUM_PADS*PAD_BITS)+1
overrun  out  1  sticky: more shifts than readable bits since last latch

Behaviour:
- Reset: all shift registers = all FILL_BIT; famicom_data = {NUM_PADS{FILL_BIT}}; bit_count = 0; overrun = 0; chain_q = 0; edge-detect history = 0.
- Load word per pad: pad 0 = ~pad_buttons[0 +: PAD_BITS] & kbd_n; pad p>0 = ~pad_buttons[p*PAD_BITS +: PAD_BITS].
- Latch is level-sensitive: every cycle famicom_latch = 1, all pad registers reload from live inputs, chain_q <= chain_en, bit_count <= 0, overrun <= 0.
- Shift event: cycle where famicom_pulse = 1 and previous-cycle pulse = 0, and latch = 0.
- Parallel (chain_q = 0): each pad register shifts right by one, FILL_BIT enters at MSB. Readable length = PAD_BITS.
- Chain (chain_q = 1): the registers form one NUM_PADS*PAD_BITS shift register, pad 0 LSB first, FILL_BIT enters at pad NUM_PADS-1 MSB. Readable length = NUM_PADS*PAD_BITS. famicom_data[0] carries the chain; data[p>0] = FILL_BIT.
- famicom_data[p] = register bit 0 of pad p, driven directly from the flop. New value is visible 1 clk_sys after the shift or load edge.
- bit_count increments per shift event and saturates at 2^CNT_W-1.
- overrun sets on the shift event that makes bit_count exceed the readable length. It holds until the next latch or reset.
- Simultaneous latch = 1 and pulse rising edge: latch wins; no shift; count stays 0.
- A pulse held high through a latch falling edge produces no shift; a fresh rising edge is required.
- chain_en change between latches has no effect until the next latch load.
- Reset mid-read aborts it; state returns to reset values on the next edge.

Optional Feature:
- Macro FAMIPAD_SYNC_EN.
- Defined: famicom_latch and famicom_pulse each pass through a 2-flop synchronizer before load/edge detection. All latencies grow by 2 clk_sys. Needed for asynchronous external pad ports.
- Undefined: inputs are used directly (same clk_sys domain as the core). Latency is exactly 1 cycle.

Decomposition:
- famipad_pkg: FILL_RELEASED/FILL_PRESSED constants, mode encoding (MODE_PARALLEL = 0, MODE_CHAIN = 1), CNT_W width function.
- Sub-module famipad_edge_sync: optional synchronizer (under FAMIPAD_SYNC_EN) plus previous-value register. Outputs the level and a rise pulse; instantiated once each for latch and pulse.
- Main block holds the shift registers, counter, overrun and chain_q.

Test Plan:
- Reset check (NUM_PADS=2, PAD_BITS=8): assert reset 3 cycles -> famicom_data=2'b11, bit_count=0, overrun=0.
- Parallel read: pad0=8'h05, kbd_n=8'hFF, latch 1 cycle, 8 pulses -> data[0] reads 0,1,0,1,1,1,1,1; bit_count=8, overrun=0.
- Over-read: continue to 9th pulse -> data[0]=1 (FILL_BIT), overrun=1. Next latch -> overrun=0.
- Keyboard merge: pad0=8'h00, kbd_n=8'hFE, latch -> data[0]=0 before any pulse; after 1 pulse data[0]=1.
- Chain read: chain_en=1, pad0=8'h01, pad1=8'h80, latch, 16 pulses -> data[0]: 0 at read 1, 1 for reads 2-15, 0 at read 16; data[1] constant 1; 17th pulse sets overrun.
- Latch priority and mode hold: latch high during 3 pulse edges -> bit_count=0; pad0 bit0 press mid-latch shows on data[0] 1 cycle later. Toggle chain_en mid-read -> shift behaviour unchanged until next latch.

Source files
------------

// File: rtl/famipad_pkg.sv
// Shared constants and helpers for the Famicom pad serializer.
package famipad_pkg;

  localparam logic FILL_RELEASED = 1'b1;
  localparam logic FILL_PRESSED  = 1'b0;

  typedef enum logic {
    MODE_PARALLEL = 1'b0,
    MODE_CHAIN    = 1'b1
  } mode_e;

  // Counter must hold NUM_PADS*PAD_BITS plus one extra shift to flag an over-read.
  function automatic int cnt_w(input int num_pads, input int pad_bits);
    return $clog2(num_pads * pad_bits) + 1;
  endfunction

endpackage

// File: rtl/famipad_edge_sync.sv
// Level/rise detector for one core control line; FAMIPAD_SYNC_EN inserts a 2-flop synchronizer.
module famipad_edge_sync (
  input  logic clk_sys,
  input  logic reset,
  input  logic in_i,
  output logic level_o,
  output logic rise_o
);

`ifdef FAMIPAD_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk_sys) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], in_i};
  end

  assign level_o = sync_q[1];
`else
  assign level_o = in_i;
`endif

  logic prev_q;

  always_ff @(posedge clk_sys) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= level_o;
  end

  assign rise_o = level_o & ~prev_q;

endmodule

// File: rtl/famipad_serializer.sv
// Multi-pad Famicom latch/pulse/data serializer with parallel or daisy-chain readout.
// Optional FAMIPAD_SYNC_EN synchronizes famicom_latch/famicom_pulse (adds 2 clk_sys latency).
module famipad_serializer
  import famipad_pkg::*;
#(
  parameter int   NUM_PADS = 2,
  parameter int   PAD_BITS = 8,
  parameter logic FILL_BIT = FILL_RELEASED,
  localparam int  CNT_W    = cnt_w(NUM_PADS, PAD_BITS)
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         chain_en,
  input  logic [NUM_PADS*PAD_BITS-1:0] pad_buttons,
  input  logic [PAD_BITS-1:0]          kbd_n,
  input  logic                         famicom_latch,
  input  logic                         famicom_pulse,
  output logic [NUM_PADS-1:0]          famicom_data,
  output logic [CNT_W-1:0]             bit_count,
  output logic                         overrun
);

  localparam int TOTAL = NUM_PADS * PAD_BITS;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W:0]   LEN_PAR   = (CNT_W+1)'(PAD_BITS);
  localparam logic [CNT_W:0]   LEN_CHAIN = (CNT_W+1)'(TOTAL);

  logic latch_lvl, latch_rise_unused;
  logic pulse_lvl, pulse_rise;

  famipad_edge_sync u_latch_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in_i    (famicom_latch),
    .level_o (latch_lvl),
    .rise_o  (latch_rise_unused)
  );

  famipad_edge_sync u_pulse_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .in_i    (famicom_pulse),
    .level_o (pulse_lvl),
    .rise_o  (pulse_rise)
  );

  // Pad p lives in sr[p*PAD_BITS +: PAD_BITS]; pad 0 at the LSB makes chain mode a plain shift.
  logic [TOTAL-1:0]    sr_q, sr_d;
  logic [NUM_PADS-1:0] data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W:0]      cnt_inc;
  logic [CNT_W:0]      readable;
  logic                ovr_q, ovr_d;
  mode_e               chain_q, chain_d;

  always_comb begin
    sr_d     = sr_q;
    chain_d  = chain_q;
    cnt_d    = cnt_q;
    ovr_d    = ovr_q;
    cnt_inc  = {1'b0, cnt_q} + 1'b1;
    readable = (chain_q == MODE_CHAIN) ? LEN_CHAIN : LEN_PAR;
    data_d   = '0;

    if (latch_lvl) begin
      for (int unsigned p = 0; p < NUM_PADS; p++) begin
        sr_d[p*PAD_BITS +: PAD_BITS] = ~pad_buttons[p*PAD_BITS +: PAD_BITS];
      end
      sr_d[PAD_BITS-1:0] = ~pad_buttons[PAD_BITS-1:0] & kbd_n;
      chain_d = mode_e'(chain_en);
      cnt_d   = '0;
      ovr_d   = 1'b0;
    end else if (pulse_rise) begin
      if (chain_q == MODE_CHAIN) begin
        sr_d = {FILL_BIT, sr_q[TOTAL-1:1]};
      end else begin
        for (int unsigned p = 0; p < NUM_PADS; p++) begin
          sr_d[p*PAD_BITS +: PAD_BITS] = {FILL_BIT, sr_q[p*PAD_BITS+1 +: PAD_BITS-1]};
        end
      end
      cnt_d = cnt_inc[CNT_W] ? CNT_MAX : cnt_inc[CNT_W-1:0];
      if (cnt_inc > readable) ovr_d = 1'b1;
    end

    // Output bits are registered from next-state so famicom_data comes straight from a flop.
    for (int unsigned p = 0; p < NUM_PADS; p++) begin
      data_d[p] = (chain_d == MODE_CHAIN && p != 0) ? FILL_BIT : sr_d[p*PAD_BITS];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sr_q    <= {TOTAL{FILL_BIT}};
      data_q  <= {NUM_PADS{FILL_BIT}};
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      chain_q <= MODE_PARALLEL;
    end else begin
      sr_q    <= sr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      chain_q <= chain_d;
    end
  end

  assign famicom_data = data_q;
  assign bit_count    = cnt_q;
  assign overrun      = ovr_q;

endmodule
